jacobian_to_affine: RTL

//  Converts a Jacobian point (X,Y,Z) from the point-add/double datapath into affine (x,y) = (X/Z^2, Y/Z^3) mod p.

---
 rtl/ecc_pkg.sv | 24 ++
 rtl/mod_inverse_binary.sv | 101 ++++++++++
 rtl/modular_multiplication.sv | 59 +++++
 rtl/jacobian_to_affine.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: field-element width and type, the Jacobian-to-affine FSM
// state encoding, and the NIST P-256 prime and base point.
package ecc_pkg;

   localparam int ECC_W = 256;

   typedef logic [ECC_W-1:0] fe_t;

   typedef enum logic [2:0] {
      J2A_IDLE,
      J2A_ZCHK,
      J2A_INV,
      J2A_M_ZI2,
      J2A_M_ZI3,
      J2A_M_X,
      J2A_M_Y,
      J2A_DONE
   } j2a_state_e;

   localparam fe_t P256_P  = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
   localparam fe_t P256_GX = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
   localparam fe_t P256_GY = 256'h4FE342E2FE1A7F9B8E7EB4A7C0F9E162BCE33576B315ECECBBB6406837BF51F5;

endpackage

// File: rtl/mod_inverse_binary.sv
// Binary extended-Euclid modular inverse, one step per cycle. ready/err are one-cycle
// pulses at termination; result holds the inverse until the next start.
module mod_inverse_binary
   import ecc_pkg::*;
#(
   parameter int WIDTH    = ECC_W,
   parameter int ITER_MAX = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] result,
   output logic             ready,
   output logic             err
);

   localparam int            CW    = $clog2(ITER_MAX + 1);
   localparam logic [CW-1:0] LIMIT = CW'(ITER_MAX);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] u_q, v_q, x1_q, x2_q, m_q, res_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, ready_q, err_q;

   // x/2 mod m for odd m; the sum x+m needs one extra bit before the shift
   function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] md);
      logic [WIDTH:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
      return s[WIDTH:1];
   endfunction

   function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] md);
      return (x >= y) ? (x - y) : (x - y + md);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         u_q     <= '0;
         v_q     <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         m_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         if (start) begin
            u_q    <= a;
            v_q    <= m;
            m_q    <= m;
            x1_q   <= ONE;
            x2_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            // u==0 means gcd(a,m)=v>1, so no inverse exists
            if (u_q == '0 || cnt_q == LIMIT) begin
               err_q  <= 1'b1;
               busy_q <= 1'b0;
            end else if (u_q == ONE) begin
               res_q   <= x1_q;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end else if (v_q == ONE) begin
               res_q   <= x2_q;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
               if (!u_q[0]) begin
                  u_q  <= u_q >> 1;
                  x1_q <= half_mod(x1_q, m_q);
               end else if (!v_q[0]) begin
                  v_q  <= v_q >> 1;
                  x2_q <= half_mod(x2_q, m_q);
               end else if (u_q >= v_q) begin
                  u_q  <= u_q - v_q;
                  x1_q <= sub_mod(x1_q, x2_q, m_q);
               end else begin
                  v_q  <= v_q - u_q;
                  x2_q <= sub_mod(x2_q, x1_q, m_q);
               end
            end
         end
      end
   end

   assign result = res_q;
   assign ready  = ready_q;
   assign err    = err_q;

endmodule

// File: rtl/modular_multiplication.sv
// Bit-serial interleaved modular multiplier: result = a*b mod m, one bit of b per cycle, MSB first.
// ready is low while a product is in flight; a, b must be < m and m odd.
module modular_multiplication #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] result,
   output logic             ready
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] a_q, b_q, m_q, r_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic [WIDTH:0]   dbl, acc;
   logic [WIDTH-1:0] r_d;

   // r <- 2r + b_i*a, each sum reduced by one conditional subtraction since both terms are < m
   always_comb begin
      dbl = {r_q, 1'b0};
      if (dbl >= {1'b0, m_q}) dbl = dbl - {1'b0, m_q};
      acc = {1'b0, dbl[WIDTH-1:0]} + (b_q[WIDTH-1] ? {1'b0, a_q} : '0);
      if (acc >= {1'b0, m_q}) acc = acc - {1'b0, m_q};
      r_d = acc[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         a_q    <= a;
         b_q    <= b;
         m_q    <= m;
         r_q    <= '0;
         cnt_q  <= CW'(WIDTH);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         r_q   <= r_d;
         b_q   <= b_q << 1;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end
   end

   assign result = r_q;
   assign ready  = !busy_q;

endmodule

// File: rtl/jacobian_to_affine.sv
// Jacobian (X,Y,Z) -> affine (X/Z^2, Y/Z^3) mod p using one inverter and one shared multiplier.
// i_start is taken only in IDLE; o_done pulses once, outputs then hold. J2A_CYCLE_COUNT_EN adds o_cycles.
module jacobian_to_affine
   import ecc_pkg::*;
#(
   parameter int WIDTH    = ECC_W,
   parameter int ITER_MAX = 1024
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [WIDTH-1:0] Z,
   output logic [WIDTH-1:0] x_aff,
   output logic [WIDTH-1:0] y_aff,
   output logic             o_inf,
   output logic             o_err,
   output logic             o_busy,
   output logic             o_done,
`ifdef J2A_CYCLE_COUNT_EN
   output logic [31:0]      o_cycles,
`endif
   output j2a_state_e       o_dbg_state
);

   j2a_state_e       state_q, state_d;
   logic [WIDTH-1:0] p_q, xin_q, yin_q, z_q, zi2_q, zi3_q, xr_q, yr_q, x_aff_q, y_aff_q;
   logic             inf_q, err_q, busy_q, done_q, mul_run_q;
   logic             accept, inv_start, inv_ready, inv_err;
   logic             mul_phase, mul_start, mul_done, mul_ready;
   logic [WIDTH-1:0] inv_res, mul_res, mul_a, mul_b;

   assign accept    = (state_q == J2A_IDLE) && i_start;
   assign mul_phase = state_q inside {J2A_M_ZI2, J2A_M_ZI3, J2A_M_X, J2A_M_Y};
   // the multiplier still shows ready from its previous job during the start cycle
   assign mul_start = mul_phase && !mul_run_q;
   assign mul_done  = mul_phase && mul_run_q && mul_ready;

   always_comb begin
      state_d   = state_q;
      inv_start = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      unique case (state_q)
         J2A_IDLE: if (i_start) state_d = J2A_ZCHK;
         J2A_ZCHK: begin
            if (z_q == '0) begin
               state_d = J2A_DONE;
            end else begin
               inv_start = 1'b1;
               state_d   = J2A_INV;
            end
         end
         J2A_INV: begin
            if (inv_err)        state_d = J2A_DONE;
            else if (inv_ready) state_d = J2A_M_ZI2;
         end
         J2A_M_ZI2: begin
            mul_a = inv_res;
            mul_b = inv_res;
            if (mul_done) state_d = J2A_M_ZI3;
         end
         J2A_M_ZI3: begin
            mul_a = zi2_q;
            mul_b = inv_res;
            if (mul_done) state_d = J2A_M_X;
         end
         J2A_M_X: begin
            mul_a = xin_q;
            mul_b = zi2_q;
            if (mul_done) state_d = J2A_M_Y;
         end
         J2A_M_Y: begin
            mul_a = yin_q;
            mul_b = zi3_q;
            if (mul_done) state_d = J2A_DONE;
         end
         J2A_DONE: state_d = J2A_IDLE;
         default:  state_d = J2A_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= J2A_IDLE;
         mul_run_q <= 1'b0;
         p_q       <= '0;
         xin_q     <= '0;
         yin_q     <= '0;
         z_q       <= '0;
         zi2_q     <= '0;
         zi3_q     <= '0;
         xr_q      <= '0;
         yr_q      <= '0;
         x_aff_q   <= '0;
         y_aff_q   <= '0;
         inf_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         if (mul_start)     mul_run_q <= 1'b1;
         else if (mul_done) mul_run_q <= 1'b0;
         // xr/yr cleared here so the infinity and error paths publish zeros
         if (accept) begin
            p_q    <= p;
            xin_q  <= X;
            yin_q  <= Y;
            z_q    <= Z;
            xr_q   <= '0;
            yr_q   <= '0;
            inf_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
         end
         if (state_q == J2A_ZCHK && z_q == '0) inf_q <= 1'b1;
         if (state_q == J2A_INV && inv_err)    err_q <= 1'b1;
         if (mul_done) begin
            if (state_q == J2A_M_ZI2) zi2_q <= mul_res;
            if (state_q == J2A_M_ZI3) zi3_q <= mul_res;
            if (state_q == J2A_M_X)   xr_q  <= mul_res;
            if (state_q == J2A_M_Y)   yr_q  <= mul_res;
         end
         if (state_q == J2A_DONE) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            x_aff_q <= xr_q;
            y_aff_q <= yr_q;
         end
      end
   end

`ifdef J2A_CYCLE_COUNT_EN
   logic [31:0] cycles_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)    cycles_q <= '0;
      else if (accept) cycles_q <= '0;
      else if (busy_q) cycles_q <= cycles_q + 32'd1;
   end

   assign o_cycles = cycles_q;
`endif

   mod_inverse_binary #(
      .WIDTH    (WIDTH),
      .ITER_MAX (ITER_MAX)
   ) u_inv (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .start  (inv_start),
      .a      (z_q),
      .m      (p_q),
      .result (inv_res),
      .ready  (inv_ready),
      .err    (inv_err)
   );

   modular_multiplication #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .start  (mul_start),
      .a      (mul_a),
      .b      (mul_b),
      .m      (p_q),
      .result (mul_res),
      .ready  (mul_ready)
   );

   assign x_aff       = x_aff_q;
   assign y_aff       = y_aff_q;
   assign o_inf       = inf_q;
   assign o_err       = err_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_dbg_state = state_q;

endmodule
